// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, stall masks, stall bit indices and divide FSM states
package pipe_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int REG_W = 5;
  localparam int STALL_W = 5;
  localparam logic [STALL_W-1:0] MASK_IF = 5'b00001;
  localparam logic [STALL_W-1:0] MASK_ID = 5'b00011;
  localparam logic [STALL_W-1:0] MASK_EX = 5'b00111;
  localparam logic [STALL_W-1:0] MASK_MEM = 5'b01111;
  localparam int ST_PC = 0;
  localparam int ST_IFID = 1;
  localparam int ST_IDEX = 2;
  localparam int ST_EXMEM = 3;
  localparam int ST_MEMWB = 4;
  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
endpackage

// File: rtl/pipe_div_timer.sv
// pipe_div_timer: times the EX stall of a multi-cycle divide and raises the abort pulse on flush
module pipe_div_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  output logic active,
  output logic div_cancel
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  div_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  // state and counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= DIV_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // start loads DIV_CYCLES-1; BUSY counts down and leaves after the cnt==1 cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (flush) begin
      state_n = DIV_IDLE;
      cnt_n = '0;
    end else if (state == DIV_IDLE && start) begin
      state_n = DIV_BUSY;
      cnt_n = CW'(DIV_CYCLES - 1);
    end else if (state == DIV_BUSY) begin
      cnt_n = cnt - 1'b1;
      state_n = (cnt == CW'(1)) ? DIV_IDLE : DIV_BUSY;
    end
  end
  assign active = start || state == DIV_BUSY;
  assign div_cancel = flush && active;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, holds ID redirects until the PC accepts them, applies flushes
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_branch_flag,
  input  logic [ADDR_W-1:0] id_branch_addr,
  input  logic              id_is_branch,
  input  logic [REG_W-1:0]  id_rs_addr,
  input  logic [REG_W-1:0]  id_rt_addr,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_wr_addr,
  input  logic              mem_is_load,
  input  logic [REG_W-1:0]  mem_wr_addr,
  input  logic              ex_div_start,
  input  logic              mem_stall_req,
  input  logic              exc_flush,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic [STALL_W-1:0] stall,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              div_cancel
);
  logic ex_active, rs_hit, rt_hit, hazard, taken;
  logic pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [STALL_W-1:0] raw;
  pipe_div_timer #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk(clk), .rst(rst), .start(ex_div_start), .flush(exc_flush),
    .active(ex_active), .div_cancel(div_cancel)
  );
  assign rs_hit = id_use_rs && id_rs_addr != '0 &&
                  ((ex_is_load && ex_wr_addr == id_rs_addr) || (mem_is_load && mem_wr_addr == id_rs_addr));
  assign rt_hit = id_use_rt && id_rt_addr != '0 &&
                  ((ex_is_load && ex_wr_addr == id_rt_addr) || (mem_is_load && mem_wr_addr == id_rt_addr));
  assign hazard = id_is_branch && (rs_hit || rt_hit);
  assign raw = ({STALL_W{if_stall_req}} & MASK_IF) | ({STALL_W{hazard}} & MASK_ID) |
               ({STALL_W{ex_active}} & MASK_EX) | ({STALL_W{mem_stall_req}} & MASK_MEM);
  assign stall = exc_flush ? '0 : raw;
  assign flush = exc_flush;
  assign taken = id_branch_flag && !hazard && !raw[ST_IDEX];
  // redirect source priority: exception, then held target, then a fresh unstalled branch
  always_comb begin
    redirect_valid = exc_flush || pend_valid || (taken && !raw[ST_PC]);
    redirect_addr = exc_flush ? exc_pc : pend_valid ? pend_addr : taken ? id_branch_addr : '0;
  end
  // hold a taken target while the PC is stalled; release on the first unstalled cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr <= '0;
    end else if (exc_flush) pend_valid <= 1'b0;
    else if (pend_valid) pend_valid <= raw[ST_PC];
    else if (taken && raw[ST_PC]) begin
      pend_valid <= 1'b1;
      pend_addr <= id_branch_addr;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall merging, hazard, divide timing, pending redirect and flush
module tb_pipe_ctrl;
  logic clk = 0, rst;
  logic if_stall_req, id_branch_flag, id_is_branch, id_use_rs, id_use_rt;
  logic ex_is_load, mem_is_load, ex_div_start, mem_stall_req, exc_flush;
  logic [31:0] id_branch_addr, exc_pc, redirect_addr;
  logic [4:0] id_rs_addr, id_rt_addr, ex_wr_addr, mem_wr_addr, stall;
  logic flush, redirect_valid, div_cancel;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .if_stall_req(if_stall_req), .id_branch_flag(id_branch_flag),
    .id_branch_addr(id_branch_addr), .id_is_branch(id_is_branch), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .mem_is_load(mem_is_load),
    .mem_wr_addr(mem_wr_addr), .ex_div_start(ex_div_start), .mem_stall_req(mem_stall_req),
    .exc_flush(exc_flush), .exc_pc(exc_pc), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .div_cancel(div_cancel)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {if_stall_req, id_branch_flag, id_is_branch, id_use_rs, id_use_rt} = '0;
    {ex_is_load, mem_is_load, ex_div_start, mem_stall_req, exc_flush} = '0;
    {id_branch_addr, exc_pc} = '0;
    {id_rs_addr, id_rt_addr, ex_wr_addr, mem_wr_addr} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    rst = 1;
    tick();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    rst = 0;
    tick();
    // load-use branch hazard on rs from EX, then from MEM, then released
    id_is_branch = 1; id_use_rs = 1; id_rs_addr = 5; id_branch_flag = 1; id_branch_addr = 32'h0040_0200;
    ex_is_load = 1; ex_wr_addr = 5;
    #1;
    chk("lu_ex_stall", 32'(stall), 32'b00011);
    chk("lu_ex_rv", 32'(redirect_valid), 0);
    tick();
    ex_is_load = 0; mem_is_load = 1; mem_wr_addr = 5;
    #1;
    chk("lu_mem_stall", 32'(stall), 32'b00011);
    chk("lu_mem_rv", 32'(redirect_valid), 0);
    tick();
    mem_is_load = 0;
    #1;
    chk("lu_go_stall", 32'(stall), 0);
    chk("lu_go_rv", 32'(redirect_valid), 1);
    chk("lu_go_addr", redirect_addr, 32'h0040_0200);
    tick();
    // rt hazard, and the same rt ignored when not a real operand
    clr(); id_is_branch = 1; id_use_rt = 1; id_rt_addr = 9; mem_is_load = 1; mem_wr_addr = 9;
    #1;
    chk("rt_stall", 32'(stall), 32'b00011);
    id_use_rt = 0;
    #1;
    chk("rt_unused", 32'(stall), 0);
    tick();
    // register 0 never creates a hazard
    clr(); id_is_branch = 1; id_use_rs = 1; id_branch_flag = 1; id_branch_addr = 32'h0000_1234;
    ex_is_load = 1;
    #1;
    chk("r0_stall", 32'(stall), 0);
    chk("r0_addr", redirect_addr, 32'h0000_1234);
    tick();
    // four-cycle divide with a MEM stall pulse at t+2
    clr(); ex_div_start = 1;
    #1;
    chk("div_t0", 32'(stall), 32'b00111);
    tick(); ex_div_start = 0; #1;
    chk("div_t1", 32'(stall), 32'b00111);
    tick(); mem_stall_req = 1; #1;
    chk("div_t2", 32'(stall), 32'b01111);
    tick(); mem_stall_req = 0; #1;
    chk("div_t3", 32'(stall), 32'b00111);
    tick(); #1;
    chk("div_t4", 32'(stall), 0);
    chk("div_nocan", 32'(div_cancel), 0);
    tick();
    // branch taken under an IF stall is held until the PC is free
    clr(); id_branch_flag = 1; id_branch_addr = 32'h0040_0100; if_stall_req = 1;
    #1;
    chk("pend_t0_stall", 32'(stall), 32'b00001);
    tick(); id_branch_flag = 0; id_branch_addr = 32'h0; #1;
    chk("pend_t1_rv", 32'(redirect_valid), 1);
    chk("pend_t1_addr", redirect_addr, 32'h0040_0100);
    tick(); #1;
    chk("pend_t2_addr", redirect_addr, 32'h0040_0100);
    tick(); if_stall_req = 0; #1;
    chk("pend_t3_rv", 32'(redirect_valid), 1);
    chk("pend_t3_addr", redirect_addr, 32'h0040_0100);
    tick(); #1;
    chk("pend_clr_rv", 32'(redirect_valid), 0);
    tick();
    // exception during BUSY with a pending redirect
    clr(); id_branch_flag = 1; id_branch_addr = 32'h0040_0300; if_stall_req = 1;
    tick(); id_branch_flag = 0; ex_div_start = 1; #1;
    chk("exc_pre_stall", 32'(stall), 32'b00111);
    chk("exc_pre_addr", redirect_addr, 32'h0040_0300);
    tick(); ex_div_start = 0; if_stall_req = 0; exc_flush = 1; exc_pc = 32'hBFC0_0380; #1;
    chk("exc_flush", 32'(flush), 1);
    chk("exc_stall", 32'(stall), 0);
    chk("exc_cancel", 32'(div_cancel), 1);
    chk("exc_addr", redirect_addr, 32'hBFC0_0380);
    tick(); exc_flush = 0; #1;
    chk("exc_post_rv", 32'(redirect_valid), 0);
    chk("exc_post_stall", 32'(stall), 0);
    chk("exc_post_cancel", 32'(div_cancel), 0);
    tick();
    // async reset mid-divide and mid-pending
    clr(); id_branch_flag = 1; id_branch_addr = 32'h0040_0400; if_stall_req = 1;
    tick(); id_branch_flag = 0; ex_div_start = 1;
    tick(); clr();
    #1;
    chk("ar_pre_stall", 32'(stall), 32'b00111);
    #2 rst = 1;
    #1;
    chk("ar_stall", 32'(stall), 0);
    chk("ar_rv", 32'(redirect_valid), 0);
    chk("ar_cancel", 32'(div_cancel), 0);
    chk("ar_flush", 32'(flush), 0);
    tick(); rst = 0;
    tick(); #1;
    chk("ar_after", 32'(stall), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
